dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, data memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, data word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1, core load/store request valid.
REQ-006 The block SHALL have port req_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 The block SHALL have port req_mode, input, 1, address mode: 0 = direct (`DMEM_IMM_ADDRESS), 1 = register-indirect (`DMEM_REG_ADDRESS).
REQ-009 The block SHALL have ports req_addr_imm and req_addr_reg, input, ADDR_W each, the direct and register-indirect addresses.
REQ-010 The block SHALL have port req_wdata, input, DATA_W, store data.
REQ-011 The block SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1) and rsp_rdata (output, DATA_W), the completion handshake and load data.
REQ-012 The block SHALL have downstream outputs dmem_write (1), dmem_addr_sel (1), dmem_addr_imm (ADDR_W), dmem_addr_reg (ADDR_W) and dmem_data_w (DATA_W), plus input dmem_data_r (DATA_W), all connecting to the data memory interface.
REQ-013 The block SHALL have port wait_cfg, input, 4, extra wait states per access; present only with DMEM_WAIT_EN.

Function
REQ-014 The FSM SHALL have states IDLE, ADDR, WAIT, CAPT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 On a rising edge with req_valid=1 in IDLE, the block SHALL latch req_we, req_mode, both addresses, req_wdata and wait_cfg, then enter ADDR.
REQ-016 ADDR SHALL last 1 cycle, then go to WAIT if latched wait count N>0; otherwise to CAPT for a load or RESP for a store.
REQ-017 WAIT SHALL last exactly N cycles, using a down-counter loaded with N; it SHALL then exit to CAPT for a load or RESP for a store.
REQ-018 CAPT SHALL last 1 cycle; on its closing edge rsp_rdata SHALL load dmem_data_r.
REQ-019 rsp_valid SHALL be 1 only in RESP; it SHALL stay asserted, with rsp_rdata stable, until an edge with rsp_ready=1, then return to IDLE.
REQ-020 Latency from the accepting edge to the first rsp_valid=1 cycle SHALL be 3+N cycles for loads and 2+N cycles for stores.
REQ-021 dmem_write SHALL be 1 during ADDR and WAIT of a store and 0 in all other cycles.
REQ-022 dmem_addr_sel, dmem_addr_imm, dmem_addr_reg and dmem_data_w SHALL be driven from latched values, stable from ADDR through RESP, holding their last values in IDLE.
REQ-023 A store SHALL leave rsp_rdata unchanged.
REQ-024 Request inputs outside IDLE SHALL be ignored; wait_cfg changes mid-access SHALL have no effect.
REQ-025 If rsp_ready is already 1 on entering RESP, rsp_valid SHALL be high for exactly 1 cycle; the next request is accepted no earlier than the following cycle (IDLE).

Reset
REQ-026 On an edge with rst=0, from any state including mid-access, the FSM SHALL go to IDLE and the wait counter SHALL clear.
REQ-027 After reset, outputs SHALL be: req_ready=1, rsp_valid=0, rsp_rdata=0, dmem_write=0, dmem_addr_sel=0, dmem_addr_imm=0, dmem_addr_reg=0, dmem_data_w=0.
REQ-028 An access aborted by reset SHALL produce no response.

Configuration
REQ-029 With macro DMEM_WAIT_EN defined, wait_cfg and the WAIT state with its counter SHALL be compiled in.
REQ-030 Without DMEM_WAIT_EN, wait_cfg and WAIT SHALL be absent, N SHALL be 0, and the latencies SHALL be 3 cycles for loads and 2 cycles for stores.

Verification
REQ-031 The bench SHALL cover a reset mid-access: rst=0 during WAIT -> IDLE next cycle, dmem_write=0, no rsp_valid, all REQ-027 values.
REQ-032 The bench SHALL cover a direct store: req_we=1, mode=0, addr_imm=0x3C, wdata=0xA5, N=0 -> dmem_write=1 for 1 cycle, addr_sel=0, data_w=0xA5, rsp_valid at cycle 2.
REQ-033 The bench SHALL cover an indirect load: mode=1, addr_reg=0x81, dmem_data_r=0x5A, N=0 -> addr_sel=1, rsp_rdata=0x5A with rsp_valid at cycle 3.
REQ-034 The bench SHALL cover wait states (DMEM_WAIT_EN): load with wait_cfg=5 -> rsp_valid at cycle 8; wait_cfg=2 applied mid-access -> latency unchanged.
REQ-035 The bench SHALL cover response backpressure: rsp_ready=0 for 4 cycles in RESP -> rsp_valid and rsp_rdata held, req_ready=0 with req_valid=1 ignored; rsp_ready=1 -> IDLE next cycle.
REQ-036 The bench SHALL cover back-to-back accesses: store 0x11 to 0x10, then load from 0x10 -> second request accepted only in IDLE, rsp_rdata=0x11.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit sequencing one data-memory access per request (IDLE/ADDR/WAIT/CAPT/RESP).
// Optional wait states (wait_cfg input, WAIT state, down-counter) are compiled in with DMEM_WAIT_EN.
module dmem_lsu #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_mode,
  input  logic [ADDR_W-1:0] req_addr_imm,
  input  logic [ADDR_W-1:0] req_addr_reg,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              dmem_write,
  output logic              dmem_addr_sel,
  output logic [ADDR_W-1:0] dmem_addr_imm,
  output logic [ADDR_W-1:0] dmem_addr_reg,
  output logic [DATA_W-1:0] dmem_data_w,
  input  logic [DATA_W-1:0] dmem_data_r
`ifdef DMEM_WAIT_EN
  ,
  input  logic [3:0]        wait_cfg
`endif
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] CAPT = 3'd3;
  localparam logic [2:0] RESP = 3'd4;
`ifdef DMEM_WAIT_EN
  localparam logic [2:0] WAIT = 3'd2;
  logic [3:0] cnt;
`endif
  logic [2:0] state;
  logic       we_q;
  logic       in_wr;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
`ifdef DMEM_WAIT_EN
  assign in_wr = state == ADDR || state == WAIT;
`else
  assign in_wr = state == ADDR;
`endif
  assign dmem_write = we_q && in_wr;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      we_q          <= 1'b0;
      dmem_addr_sel <= 1'b0;
      dmem_addr_imm <= '0;
      dmem_addr_reg <= '0;
      dmem_data_w   <= '0;
      rsp_rdata     <= '0;
`ifdef DMEM_WAIT_EN
      cnt           <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          state         <= ADDR;
          we_q          <= req_we;
          dmem_addr_sel <= req_mode;
          dmem_addr_imm <= req_addr_imm;
          dmem_addr_reg <= req_addr_reg;
          dmem_data_w   <= req_wdata;
`ifdef DMEM_WAIT_EN
          cnt           <= wait_cfg;
`endif
        end
`ifdef DMEM_WAIT_EN
        ADDR: state <= cnt != 4'd0 ? WAIT : (we_q ? RESP : CAPT);
        // counter reaches zero on the same edge that leaves WAIT
        WAIT: begin
          if (cnt == 4'd1) state <= we_q ? RESP : CAPT;
          cnt <= cnt - 4'd1;
        end
`else
        ADDR: state <= we_q ? RESP : CAPT;
`endif
        CAPT: begin
          rsp_rdata <= dmem_data_r;
          state     <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: randomized self-checking bench for dmem_lsu against a transaction-level memory model.
// Honors DMEM_WAIT_EN: wait counts are forced to 0 when the feature is compiled out.
module tb_dmem_lsu;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0, req_mode = 1'b0, rsp_ready = 1'b0;
  logic [7:0] req_addr_imm = '0, req_addr_reg = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, dmem_write, dmem_addr_sel;
  logic [7:0] rsp_rdata, dmem_addr_imm, dmem_addr_reg, dmem_data_w, dmem_data_r;
`ifdef DMEM_WAIT_EN
  logic [3:0] wait_cfg = '0;
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mode(req_mode), .req_addr_imm(req_addr_imm), .req_addr_reg(req_addr_reg),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .dmem_write(dmem_write), .dmem_addr_sel(dmem_addr_sel), .dmem_addr_imm(dmem_addr_imm),
    .dmem_addr_reg(dmem_addr_reg), .dmem_data_w(dmem_data_w), .dmem_data_r(dmem_data_r)
`ifdef DMEM_WAIT_EN
    , .wait_cfg(wait_cfg)
`endif
  );

  // memory behind the LSU; preloaded through the poke port while in reset
  logic [7:0] mem [256];
  logic       poke = 1'b0;
  logic [7:0] poke_a = '0, poke_d = '0;
  assign dmem_data_r = mem[dmem_addr_sel ? dmem_addr_reg : dmem_addr_imm];
  always @(posedge clk)
    if (dmem_write) mem[dmem_addr_sel ? dmem_addr_reg : dmem_addr_imm] <= dmem_data_w;
    else if (poke) mem[poke_a] <= poke_d;

  logic [7:0] ref_mem [256];
  logic [7:0] exp_rdata = '0, exp_imm = '0, exp_reg = '0, exp_dw = '0;
  logic       exp_sel = 1'b0;
  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_addr(input string tag);
    check({tag, ".sel"}, dmem_addr_sel, exp_sel);
    check({tag, ".imm"}, dmem_addr_imm, exp_imm);
    check({tag, ".reg"}, dmem_addr_reg, exp_reg);
    check({tag, ".dw"}, dmem_data_w, exp_dw);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    req_valid    = 1'b1;
    req_we       = 1'($urandom);
    req_mode     = 1'($urandom);
    req_addr_imm = 8'($urandom);
    req_addr_reg = 8'($urandom);
    req_wdata    = 8'($urandom);
`ifdef DMEM_WAIT_EN
    wait_cfg     = 4'($urandom);
`endif
  endtask

  task automatic do_req(input bit we, input bit mode, input logic [7:0] imm, input logic [7:0] rg,
                        input logic [7:0] wd, input int n_in, input int stall);
    int n, lat, k, guard;
    n = WAIT_EN ? n_in : 0;
    guard = 0;
    while (!req_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_mode = mode;
    req_addr_imm = imm; req_addr_reg = rg; req_wdata = wd;
`ifdef DMEM_WAIT_EN
    wait_cfg = 4'(n);
`endif
    rsp_ready = (stall == 0);
    lat = (we ? 2 : 3) + n;
    exp_sel = mode; exp_imm = imm; exp_reg = rg; exp_dw = wd;
    if (we) ref_mem[mode ? rg : imm] = wd;
    else exp_rdata = ref_mem[mode ? rg : imm];
    tick();
    junk();
    k = 1;
    while (!rsp_valid && k < lat + 3) begin
      check("write", dmem_write, 32'(we && k <= n + 1));
      check("busy_ready", req_ready, 0);
      check_addr("flight");
      tick();
      junk();
      k++;
    end
    check("latency", k, lat);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("resp_write", dmem_write, 0);
    check("resp_ready", req_ready, 0);
    check_addr("resp");
    if (stall == 0) req_valid = 1'b0;
    for (int s = 1; s < stall; s++) begin
      tick();
      junk();
      check("hold_valid", rsp_valid, 1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("done_valid", rsp_valid, 0);
    check("done_ready", req_ready, 1);
    check("done_rdata", rsp_rdata, exp_rdata);
    check_addr("idle");
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ready"}, req_ready, 1);
    check({tag, ".valid"}, rsp_valid, 0);
    check({tag, ".rdata"}, rsp_rdata, 0);
    check({tag, ".write"}, dmem_write, 0);
    check_addr(tag);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      poke_a = 8'(i); poke_d = 8'(i) ^ 8'hDB; ref_mem[i] = 8'(i) ^ 8'hDB; poke = 1'b1;
      tick();
    end
    poke = 1'b0;
    check_reset_vals("reset");
    rst = 1'b1;
    tick();
    // direct store, indirect load (0x81 preloads to 0x5A)
    do_req(1, 0, 8'h3C, 8'hC3, 8'hA5, 0, 0);
    do_req(0, 1, 8'h07, 8'h81, 8'h00, 0, 0);
    check("ld_5a", rsp_rdata, 8'h5A);
    do_req(0, 0, 8'h3C, 8'h00, 8'h00, 5, 0);
    check("ld_a5", rsp_rdata, 8'hA5);
    do_req(0, 1, 8'h00, 8'h55, 8'h00, 2, 4);
    do_req(1, 0, 8'h10, 8'h99, 8'h11, 1, 0);
    do_req(0, 0, 8'h10, 8'h66, 8'h00, 0, 0);
    check("b2b", rsp_rdata, 8'h11);
    // store aborted by reset mid-access
    req_valid = 1'b1; req_we = 1'b1; req_mode = 1'b0;
    req_addr_imm = 8'h20; req_addr_reg = 8'h00; req_wdata = 8'h77; rsp_ready = 1'b1;
`ifdef DMEM_WAIT_EN
    wait_cfg = 4'd5;
`endif
    ref_mem[8'h20] = 8'h77;
    tick();
    junk();
    check("abort_wr", dmem_write, 1);
    if (WAIT_EN) begin
      tick();
      check("abort_wr2", dmem_write, 1);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    tick();
    exp_rdata = '0; exp_sel = 1'b0; exp_imm = '0; exp_reg = '0; exp_dw = '0;
    check_reset_vals("abort");
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_norsp", rsp_valid, 0);
      check("abort_idle", req_ready, 1);
    end
    do_req(0, 0, 8'h20, 8'h00, 8'h00, 0, 0);
    for (int t = 0; t < 40; t++)
      do_req(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
